// File: rtl/fixed_alu_pkg.sv
// Shared types for the sequential sign-magnitude fixed-point ALU.
// Op and FSM encodings, core mode constants and the sign normalisation helper.
package fixed_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDSUB = 3'd1,
        ST_MUL    = 3'd2,
        ST_DIV    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // A zero magnitude is always reported as +0.
    function automatic logic sm_norm(input logic sign, input logic mag_zero);
        return sign & ~mag_zero;
    endfunction

endpackage

// File: rtl/fixed_seq_muldiv.sv
// Iterative magnitude core: LSB-first shift-add multiply (N cycles) or restoring divide (N+FRAC_W cycles).
// done pulses one cycle after the last iteration; no backpressure, start is only honoured by an idle owner.
module fixed_seq_muldiv
    import fixed_alu_pkg::*;
#(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode,
    input  logic [INT_W+FRAC_W-1:0]           a_mag,
    input  logic [INT_W+FRAC_W-1:0]           b_mag,
    output logic                              busy,
    output logic                              done,
    output logic [2*(INT_W+FRAC_W)-1:0]       prod
);

    localparam int N  = INT_W + FRAC_W;
    localparam int CW = $clog2(N + FRAC_W);
    localparam logic [CW-1:0] LAST_MUL = CW'(N - 1);
    localparam logic [CW-1:0] LAST_DIV = CW'(N + FRAC_W - 1);

    logic            mode_q;
    logic [N-1:0]    opnd_q;
    logic [N-1:0]    rem_q;
    logic [2*N-1:0]  work_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;

    logic [N:0]      mul_sum;
    logic [N:0]      rem_sh;
    logic [N:0]      rem_diff;
    logic            qbit;
    logic [CW-1:0]   last_cnt;

    always_comb begin
        mul_sum  = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {rem_q, work_q[N+FRAC_W-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        // A set top bit means the shifted remainder already exceeds any N-bit divisor.
        qbit     = rem_sh[N] | ~rem_diff[N];
        last_cnt = (mode_q == MODE_DIV) ? LAST_DIV : LAST_MUL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_MUL;
            opnd_q <= '0;
            rem_q  <= '0;
            work_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                mode_q <= mode;
                cnt_q  <= '0;
                busy_q <= 1'b1;
                rem_q  <= '0;
                if (mode == MODE_DIV) begin
                    // Dividend |a| << FRAC_W sits in the low N+FRAC_W bits; quotient bits shift in behind it.
                    opnd_q <= b_mag;
                    work_q <= {{INT_W{1'b0}}, a_mag, {FRAC_W{1'b0}}};
                end else begin
                    opnd_q <= a_mag;
                    work_q <= {{N{1'b0}}, b_mag};
                end
            end else if (busy_q) begin
                if (mode_q == MODE_DIV) begin
                    rem_q  <= qbit ? rem_diff[N-1:0] : rem_sh[N-1:0];
                    work_q <= {work_q[2*N-2:0], qbit};
                end else begin
                    work_q <= {mul_sum, work_q[N-1:1]};
                end
                if (cnt_q == last_cnt) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = work_q;

endmodule

// File: rtl/fixed_point_alu_seq.sv
// Sign-magnitude fixed-point ADD/SUB/MUL/DIV, one op in flight; latency 1 / N+1 / N+FRAC_W+1 cycles.
// Result held until out_ready, no accept until then; FIXED_ALU_SATURATE_EN clamps overflow to max magnitude.
module fixed_point_alu_seq
    import fixed_alu_pkg::*;
#(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  op_t                       op,
    input  logic [INT_W+FRAC_W:0]     data_a,
    input  logic [INT_W+FRAC_W:0]     data_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INT_W+FRAC_W:0]     result,
    output logic                      ovf,
    output logic                      div0
);

    localparam int N = INT_W + FRAC_W;

    state_t          state_q, state_d;
    op_t             op_q;
    logic            sa_q, sb_q;
    logic [N-1:0]    ma_q, mb_q;

    logic [N:0]      result_q;
    logic            ovf_q, div0_q;

    logic            accept;
    logic            core_start, core_mode, core_busy, core_done;
    logic [2*N-1:0]  core_prod;

    logic            sb_eff;
    logic [N:0]      as_sum;
    logic            as_sign, as_ovf;
    logic [N-1:0]    as_mag;

    logic            load;
    logic            raw_sign, raw_ovf, raw_div0;
    logic [N-1:0]    raw_mag, fin_mag;

    assign in_ready  = (state_q == ST_IDLE) && !core_busy && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign div0      = div0_q;

    fixed_seq_muldiv #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (core_start),
        .mode   (core_mode),
        .a_mag  (data_a[N-1:0]),
        .b_mag  (data_b[N-1:0]),
        .busy   (core_busy),
        .done   (core_done),
        .prod   (core_prod)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= OP_ADD;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            ma_q <= '0;
            mb_q <= '0;
        end else if (accept) begin
            op_q <= op;
            sa_q <= data_a[N];
            sb_q <= data_b[N];
            ma_q <= data_a[N-1:0];
            mb_q <= data_b[N-1:0];
        end
    end

    // Sign-magnitude add; SUB is an add with b's sign flipped.
    always_comb begin
        sb_eff  = sb_q ^ (op_q == OP_SUB);
        as_sum  = {1'b0, ma_q} + {1'b0, mb_q};
        as_sign = sa_q;
        as_mag  = as_sum[N-1:0];
        as_ovf  = as_sum[N];
        if (sa_q != sb_eff) begin
            as_ovf = 1'b0;
            if (ma_q >= mb_q) begin
                as_mag = ma_q - mb_q;
            end else begin
                as_mag  = mb_q - ma_q;
                as_sign = sb_eff;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        core_mode  = MODE_MUL;
        load       = 1'b0;
        raw_sign   = 1'b0;
        raw_mag    = '0;
        raw_ovf    = 1'b0;
        raw_div0   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_ADD, OP_SUB: state_d = ST_ADDSUB;
                        OP_MUL: begin
                            core_start = 1'b1;
                            state_d    = ST_MUL;
                        end
                        default: begin
                            core_start = 1'b1;
                            core_mode  = MODE_DIV;
                            state_d    = ST_DIV;
                        end
                    endcase
                end
            end
            ST_ADDSUB: begin
                load     = 1'b1;
                raw_sign = as_sign;
                raw_mag  = as_mag;
                raw_ovf  = as_ovf;
                state_d  = ST_DONE;
            end
            ST_MUL: begin
                if (core_done) begin
                    load     = 1'b1;
                    raw_sign = sa_q ^ sb_q;
                    raw_mag  = core_prod[N+FRAC_W-1:FRAC_W];
                    raw_ovf  = |core_prod[2*N-1:N+FRAC_W];
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
                if (core_done) begin
                    load     = 1'b1;
                    raw_sign = sa_q ^ sb_q;
                    state_d  = ST_DONE;
                    if (mb_q == '0) begin
                        raw_mag  = '1;
                        raw_ovf  = 1'b1;
                        raw_div0 = 1'b1;
                    end else begin
                        raw_mag = core_prod[N-1:0];
                        raw_ovf = |core_prod[N+FRAC_W-1:N];
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FIXED_ALU_SATURATE_EN
    assign fin_mag = raw_ovf ? '1 : raw_mag;
`else
    assign fin_mag = raw_mag;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
        end else if (load) begin
            result_q <= {sm_norm(raw_sign, fin_mag == '0), fin_mag};
            ovf_q    <= raw_ovf;
            div0_q   <= raw_div0;
        end
    end

endmodule

// File: tb/tb_fixed_point_alu_seq.sv
// Scoreboard bench: issued ops push expected responses from an arithmetic model, a monitor pops and compares.
`timescale 1ns/1ps
module tb_fixed_point_alu_seq;
    import fixed_alu_pkg::*;

    localparam int INT_W  = 16;
    localparam int FRAC_W = 16;
    localparam int N      = INT_W + FRAC_W;
    localparam int W      = N + 1;
    localparam longint unsigned MAXMAG = (64'd1 << N) - 64'd1;
`ifdef FIXED_ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         div0;
        int           lat;
        int           acc;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    op_t           op;
    logic [W-1:0]  data_a;
    logic [W-1:0]  data_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          ovf;
    logic          div0;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   hold_off = 1'b1;
    bit   seen_first = 1'b0;
    bit   ready_next = 1'b0;

    fixed_point_alu_seq #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .div0      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] fx(input logic s, input logic [15:0] i, input logic [15:0] f);
        return {s, i, f};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [31:0] m;
        logic        s;
        m = $urandom;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: m = m & 32'h0003_FFFF;
            1: m = m & 32'h00FF_FFFF;
            2: m = 32'h0;
            3: m = m & 32'h0000_FFFF;
            default: ;
        endcase
        return {s, m};
    endfunction

    // Real-number view: signed values for add/sub, plain integer product/quotient for mul/div.
    function automatic exp_t model(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t            e;
        longint unsigned ma, mb, mag;
        longint          va, vb, r;
        logic            sg, ov, dz;
        ma  = a[N-1:0];
        mb  = b[N-1:0];
        dz  = 1'b0;
        sg  = a[N] ^ b[N];
        mag = 0;
        e.lat = 1;
        case (o)
            OP_ADD, OP_SUB: begin
                va  = a[N] ? -longint'(ma) : longint'(ma);
                vb  = (b[N] ^ (o == OP_SUB)) ? -longint'(mb) : longint'(mb);
                r   = va + vb;
                sg  = (r < 0);
                mag = (r < 0) ? -r : r;
            end
            OP_MUL: begin
                mag   = (ma * mb) >> FRAC_W;
                e.lat = N + 1;
            end
            default: begin
                e.lat = N + FRAC_W + 1;
                if (mb == 0) begin
                    dz  = 1'b1;
                    mag = MAXMAG;
                end else begin
                    mag = (ma << FRAC_W) / mb;
                end
            end
        endcase
        ov = dz || (mag > MAXMAG);
        if (ov) mag = SAT ? MAXMAG : (mag & MAXMAG);
        if (mag == 0) sg = 1'b0;
        e.res  = {sg, mag[N-1:0]};
        e.ovf  = ov;
        e.div0 = dz;
        e.acc  = 0;
        return e;
    endfunction

    task automatic issue(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        op = o;
        data_a = a;
        data_b = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(o, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = op_t'($urandom_range(0, 3));
        data_a = rnd_op();
        data_b = rnd_op();
    endtask

    task automatic drain(input int budget);
        int w;
        w = 0;
        while (sb.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            seen_first = 1'b0;
            ready_next = 1'b0;
        end else begin
            if (ready_next) begin
                check("in_ready_after_handshake", 64'(in_ready), 64'd1);
                ready_next = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    if (out_ready) check("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    if (!seen_first) begin
                        check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                        seen_first = 1'b1;
                    end
                    if (!out_ready) begin
                        check("stall_in_ready", 64'(in_ready), 64'd0);
                        check("stall_result", 64'(result), 64'(sb[0].res));
                    end else begin
                        e = sb.pop_front();
                        check("result", 64'(result), 64'(e.res));
                        check("ovf", 64'(ovf), 64'(e.ovf));
                        check("div0", 64'(div0), 64'(e.div0));
                        seen_first = 1'b0;
                        ready_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        reset    = 1'b1;
        in_valid = 1'b0;
        op       = OP_ADD;
        data_a   = '0;
        data_b   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_div0", 64'(div0), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", 64'(in_ready), 64'd1);
        hold_off = 1'b0;

        issue(OP_ADD, fx(0, 16'h0001, 16'h8000), fx(1, 16'h0000, 16'h4000));
        issue(OP_SUB, fx(0, 16'h0002, 16'h0000), fx(0, 16'h0002, 16'h0000));
        issue(OP_SUB, fx(1, 16'h0001, 16'h0000), fx(1, 16'h0003, 16'h0000));
        issue(OP_ADD, fx(0, 16'hFFFF, 16'h8000), fx(0, 16'h0000, 16'h8000));
        issue(OP_MUL, fx(0, 16'h0001, 16'h8000), fx(1, 16'h0002, 16'h0000));
        issue(OP_MUL, fx(0, 16'h8000, 16'h0000), fx(0, 16'h0002, 16'h0000));
        issue(OP_MUL, fx(1, 16'h0000, 16'h0001), fx(0, 16'h0000, 16'h0001));
        issue(OP_DIV, fx(0, 16'h0007, 16'h0000), fx(0, 16'h0002, 16'h0000));
        issue(OP_DIV, fx(1, 16'h0001, 16'h0000), fx(0, 16'h0000, 16'h0000));
        issue(OP_DIV, fx(0, 16'h8000, 16'h0000), fx(1, 16'h0000, 16'h4000));
        drain(500);

        // Output stall with in_valid toggling underneath it.
        hold_off = 1'b1;
        issue(OP_MUL, fx(1, 16'h0003, 16'h2000), fx(1, 16'h0004, 16'h0000));
        waited = 0;
        while (!out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) check("bp_valid_timeout", 64'(out_valid), 64'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            op = op_t'($urandom_range(0, 3));
            data_a = rnd_op();
            data_b = rnd_op();
        end
        in_valid = 1'b0;
        hold_off = 1'b0;
        drain(500);

        // Reset in the middle of a multiply.
        issue(OP_MUL, fx(0, 16'h0003, 16'h4000), fx(1, 16'h0005, 16'h0000));
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_release", 64'(in_ready), 64'd1);
        issue(OP_MUL, fx(0, 16'h0003, 16'h4000), fx(1, 16'h0005, 16'h0000));
        issue(OP_DIV, fx(1, 16'h0064, 16'h0000), fx(0, 16'h0003, 16'h0000));

        for (int k = 0; k < 40; k++) begin
            issue(op_t'($urandom_range(0, 3)), rnd_op(), rnd_op());
        end
        drain(5000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
